// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a pipelined single-port block RAM.
// Optional parity checking of read data is enabled by defining RAM_PARITY_CHECK_EN.
module ram_arbiter #(
    parameter int unsigned MEM_WIDTH = 16,
    parameter int unsigned ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_0,
    input  logic                 req_write_0,
    input  logic [ADDR_SIZE-1:0] req_addr_0,
    input  logic [MEM_WIDTH-1:0] req_wdata_0,
    input  logic                 req_valid_1,
    input  logic                 req_write_1,
    input  logic [ADDR_SIZE-1:0] req_addr_1,
    input  logic [MEM_WIDTH-1:0] req_wdata_1,
    output logic                 req_ready_0,
    output logic                 req_ready_1,
    output logic                 rsp_valid_0,
    output logic                 rsp_valid_1,
    output logic [MEM_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity_out
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWrite,
        StRead,
        StDout,
        StCapt
    } state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  din_q, din_d;
    logic                  rsp_valid_0_q, rsp_valid_0_d;
    logic                  rsp_valid_1_q, rsp_valid_1_d;
    logic [MEM_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  grant_0, grant_1, accept;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_q        <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
            rdata_q       <= rdata_d;
        end
    end

    // On a tie the requester that did not win last time is granted
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state_q == StIdle) begin
            if (req_valid_0 && req_valid_1) begin
                grant_0 = last_q;
                grant_1 = ~last_q;
            end else begin
                grant_0 = req_valid_0;
                grant_1 = req_valid_1;
            end
        end
        accept = grant_0 | grant_1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StAddr;
            StAddr:  state_d = we_q ? StWrite : StRead;
            StWrite: state_d = StIdle;
            StRead:  state_d = StDout;
            StDout:  state_d = StCapt;
            StCapt:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_addr_en    = 1'b0;
        ram_blk_select = 1'b0;
        ram_wr_en      = 1'b0;
        ram_rd_en      = 1'b0;
        ram_dout_en    = 1'b0;
        unique case (state_q)
            StAddr: ram_addr_en = 1'b1;
            StWrite: begin
                ram_addr_en    = 1'b1;
                ram_blk_select = 1'b1;
                ram_wr_en      = 1'b1;
            end
            StRead: begin
                ram_blk_select = 1'b1;
                ram_rd_en      = 1'b1;
            end
            StDout:  ram_dout_en = 1'b1;
            default: ;
        endcase
    end

    // last_q doubles as the owner of the in-flight transaction
    always_comb begin
        last_d        = last_q;
        we_d          = we_q;
        addr_d        = addr_q;
        din_d         = din_q;
        rsp_valid_0_d = 1'b0;
        rsp_valid_1_d = 1'b0;
        rdata_d       = rdata_q;
        if (accept) begin
            last_d = grant_1;
            we_d   = grant_1 ? req_write_1 : req_write_0;
            addr_d = grant_1 ? req_addr_1  : req_addr_0;
            din_d  = grant_1 ? req_wdata_1 : req_wdata_0;
        end
        if (state_q == StWrite || state_q == StCapt) begin
            rsp_valid_0_d = ~last_q;
            rsp_valid_1_d = last_q;
        end
        if (state_q == StCapt) begin
            rdata_d = ram_dout;
        end
    end

`ifdef RAM_PARITY_CHECK_EN
    logic err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == StWrite) begin
            err_d = 1'b0;
        end else if (state_q == StCapt) begin
            err_d = (^ram_dout) != ram_parity_out;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_parity;
    assign unused_parity = ram_parity_out;
    assign rsp_err       = 1'b0;
`endif

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign rsp_rdata   = rdata_q;
    assign busy        = (state_q != StIdle);
    assign ram_addr    = addr_q;
    assign ram_din     = din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: pin-level RAM model, transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_ram_arbiter;
    localparam int MW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_0 = 1'b0, req_write_0 = 1'b0;
    logic [AW-1:0] req_addr_0 = '0;
    logic [MW-1:0] req_wdata_0 = '0;
    logic          req_valid_1 = 1'b0, req_write_1 = 1'b0;
    logic [AW-1:0] req_addr_1 = '0;
    logic [MW-1:0] req_wdata_1 = '0;
    logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_err, busy;
    logic [MW-1:0] rsp_rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en;
    logic          ram_parity_out;
    logic          inject = 1'b0;

    ram_arbiter #(.MEM_WIDTH(MW), .ADDR_SIZE(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_write_0(req_write_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_write_1(req_write_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
        .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
        .ram_dout(ram_dout), .ram_parity_out(ram_parity_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MW-1:0] init_val(int i);
        return MW'(i * 291) ^ 16'h5a5a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pin-level RAM: registered address, registered array read, registered output
    logic [MW-1:0] bram [1024];
    logic [AW-1:0] b_addr_q;
    logic [MW-1:0] b_data_q = '0, b_dout_q = '0;
    bit            bram_inited = 1'b0;
    always @(posedge clk) begin
        if (!bram_inited) begin
            for (int i = 0; i < 1024; i++) bram[i] <= init_val(i);
            bram_inited <= 1'b1;
        end
        if (ram_addr_en) b_addr_q <= ram_addr;
        if (ram_blk_select && ram_wr_en) bram[b_addr_q] <= ram_din;
        if (ram_blk_select && ram_rd_en) b_data_q <= bram[b_addr_q];
        if (ram_dout_en) b_dout_q <= b_data_q;
    end
    assign ram_dout       = b_dout_q;
    assign ram_parity_out = (^b_dout_q) ^ inject;

    // Expected RAM controls {addr_en, blk_select, wr_en, rd_en, dout_en} by cycle offset
    function automatic logic [4:0] exp_ctl(int c, bit we);
        if (c == 1) return 5'b10000;
        if (c == 2) return we ? 5'b11100 : 5'b01010;
        if (c == 3 && !we) return 5'b00001;
        return 5'b00000;
    endfunction

    // Transaction-level model: m_cyc counts cycles since accept (0 = idle)
    logic [MW-1:0] mmem [1024];
    bit            mem_inited = 1'b0;
    int            m_cyc = 0;
    bit            m_last = 1'b1, m_owner = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [MW-1:0] m_data = '0, m_rdata = '0;
    bit            m_rsp0 = 1'b0, m_rsp1 = 1'b0, m_err = 1'b0;
    bit            e_rdy0, e_rdy1;
    bit            acc0 = 1'b0, acc1 = 1'b0;
    int            acc_t [2] = '{-1, -1};
    int            rsp_t [2] = '{-1, -1};
    logic [MW-1:0] rsp_d [2];
    logic          rsp_e [2];

    always @(negedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 1024; i++) mmem[i] = init_val(i);
            mem_inited = 1'b1;
        end
        e_rdy0 = (m_cyc == 0) && req_valid_0 && (!req_valid_1 || m_last);
        e_rdy1 = (m_cyc == 0) && req_valid_1 && (!req_valid_0 || !m_last);
        if (chk_en) begin
            chk("req_ready_0", req_ready_0, e_rdy0);
            chk("req_ready_1", req_ready_1, e_rdy1);
            chk("busy", busy, m_cyc != 0);
            chk("ram_ctl", {ram_addr_en, ram_blk_select, ram_wr_en, ram_rd_en, ram_dout_en},
                exp_ctl(m_cyc, m_we));
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_din", ram_din, m_data);
            chk("rsp_valid_0", rsp_valid_0, m_rsp0);
            chk("rsp_valid_1", rsp_valid_1, m_rsp1);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            if (m_rsp0 || m_rsp1) chk("rsp_err", rsp_err, m_err);
        end
        acc0 = req_valid_0 && req_ready_0;
        acc1 = req_valid_1 && req_ready_1;
        if (acc0) acc_t[0] = cyc;
        if (acc1) acc_t[1] = cyc;
        if (rsp_valid_0) begin rsp_t[0] = cyc; rsp_d[0] = rsp_rdata; rsp_e[0] = rsp_err; end
        if (rsp_valid_1) begin rsp_t[1] = cyc; rsp_d[1] = rsp_rdata; rsp_e[1] = rsp_err; end
        if (rst) begin
            if (m_cyc == 2 && m_we) mmem[m_addr] = m_data;
            m_cyc = 0; m_last = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0;
            m_rsp0 = 1'b0; m_rsp1 = 1'b0; m_rdata = '0; m_err = 1'b0;
        end else begin
            m_rsp0 = 1'b0;
            m_rsp1 = 1'b0;
            if (m_cyc == 2 && m_we) begin
                mmem[m_addr] = m_data;
                m_rsp0 = !m_owner; m_rsp1 = m_owner; m_err = 1'b0;
            end
            if (m_cyc == 4 && !m_we) begin
                m_rdata = mmem[m_addr];
                m_rsp0 = !m_owner; m_rsp1 = m_owner;
`ifdef RAM_PARITY_CHECK_EN
                m_err = inject;
`else
                m_err = 1'b0;
`endif
            end
            if (m_cyc == 0) begin
                if (e_rdy0 || e_rdy1) begin
                    m_owner = e_rdy1;
                    m_last  = e_rdy1;
                    m_we    = e_rdy1 ? req_write_1 : req_write_0;
                    m_addr  = e_rdy1 ? req_addr_1 : req_addr_0;
                    m_data  = e_rdy1 ? req_wdata_1 : req_wdata_0;
                    m_cyc   = 1;
                end
            end else if ((m_we && m_cyc == 2) || (!m_we && m_cyc == 4)) begin
                m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic set_req(input int id, input bit we, input logic [AW-1:0] a,
                           input logic [MW-1:0] d);
        if (id == 0) begin
            req_valid_0 = 1'b1; req_write_0 = we; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = 1'b1; req_write_1 = we; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // Advance one cycle; requesters drop a request once it was accepted
    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) req_valid_0 = 1'b0;
        if (acc1) req_valid_1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || req_valid_0 || req_valid_1) && n < 40) begin step(); n++; end
        chk("idle_timeout", n < 40, 1);
        step();
    endtask

    task automatic txn(input int id, input bit we, input logic [AW-1:0] a,
                       input logic [MW-1:0] d, output int lat, output logic [MW-1:0] rd,
                       output logic er);
        int n = 0;
        set_req(id, we, a, d);
        while (((id == 0) ? req_valid_0 : req_valid_1) && n < 30) begin step(); n++; end
        chk("txn_accept_timeout", n < 30, 1);
        n = 0;
        while (rsp_t[id] <= acc_t[id] && n < 30) begin step(); n++; end
        chk("txn_rsp_timeout", n < 30, 1);
        lat = rsp_t[id] - acc_t[id];
        rd  = rsp_d[id];
        er  = rsp_e[id];
    endtask

    task automatic pin_seq(input bit we);
        logic [4:0] ex [5];
        int         len;
        ex[0] = 5'b00000; ex[1] = 5'b10000;
        ex[2] = we ? 5'b11100 : 5'b01010;
        ex[3] = 5'b00001; ex[4] = 5'b00000;
        len   = we ? 2 : 4;
        set_req(0, we, 10'h030, 16'h0f0f);
        @(negedge clk);
        chk("pin_seq_ready", req_ready_0, 1);
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk(we ? "pin_seq_write" : "pin_seq_read",
                {ram_addr_en, ram_blk_select, ram_wr_en, ram_rd_en, ram_dout_en}, ex[k]);
        end
        @(posedge clk); #1;
        wait_idle();
    endtask

    int            lat;
    logic [MW-1:0] rd;
    logic          er;
    int            bt [3];
    int            n;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_ctl", {ram_addr_en, ram_blk_select, ram_wr_en, ram_rd_en, ram_dout_en}, 0);
        chk("reset_ram_addr", ram_addr, 0);
        @(posedge clk); #1;

        // Write then read from requester 0
        txn(0, 1'b1, 10'h005, 16'h1234, lat, rd, er);
        chk("wr_latency", lat, 3);
        txn(0, 1'b0, 10'h005, 16'h0000, lat, rd, er);
        chk("rd_latency", lat, 5);
        chk("rd_data", rd, 16'h1234);
        chk("rd_err", er, 0);
        wait_idle();

        // Both requesters right after reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b1, 10'h010, 16'haaaa);
        set_req(1, 1'b1, 10'h011, 16'h5555);
        wait_idle();
        chk("dual_w_gap", acc_t[1] - acc_t[0], 3);
        chk("dual_w_rsp0", rsp_t[0] - acc_t[0], 3);
        set_req(0, 1'b0, 10'h010, 16'h0000);
        set_req(1, 1'b0, 10'h011, 16'h0000);
        wait_idle();
        chk("dual_r_gap", acc_t[1] - acc_t[0], 5);
        chk("dual_r_data0", rsp_d[0], 16'haaaa);
        chk("dual_r_data1", rsp_d[1], 16'h5555);

        // Back-to-back reads from requester 1
        set_req(1, 1'b0, 10'h010, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!acc1 && n < 20);
            chk("b2b_timeout", n < 20, 1);
            bt[k] = acc_t[1];
            req_addr_1 = 10'h011;
        end
        req_valid_1 = 1'b0;
        wait_idle();
        chk("b2b_gap1", bt[1] - bt[0], 5);
        chk("b2b_gap2", bt[2] - bt[1], 5);

        // Reset during DOUT of a read
        set_req(0, 1'b0, 10'h011, 16'h0000);
        n = 0;
        while (req_valid_0 && n < 20) begin step(); n++; end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_dout", ram_dout_en, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(1, 1'b1, 10'h020, 16'hbeef);
        @(negedge clk);
        chk("rst_no_rsp", {rsp_valid_0, rsp_valid_1}, 0);
        chk("rst_ctl_zero", {ram_addr_en, ram_blk_select, ram_wr_en, ram_rd_en, ram_dout_en}, 0);
        chk("rst_addr_zero", ram_addr, 0);
        chk("rst_accept", req_ready_1, 1);
        step();
        wait_idle();

        // Parity injection on a read
        inject = 1'b1;
        txn(0, 1'b0, 10'h020, 16'h0000, lat, rd, er);
        inject = 1'b0;
        chk("par_data", rd, 16'hbeef);
`ifdef RAM_PARITY_CHECK_EN
        chk("par_err", er, 1);
`else
        chk("par_err", er, 0);
`endif
        wait_idle();

        pin_seq(1'b1);
        pin_seq(1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step();
            inject = ($urandom_range(0, 3) == 0);
            if (!req_valid_0 && $urandom_range(0, 2) == 0)
                set_req(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), MW'($urandom));
            if (!req_valid_1 && $urandom_range(0, 2) == 0)
                set_req(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), MW'($urandom));
        end
        n = 0;
        while ((req_valid_0 || req_valid_1) && n < 60) begin step(); n++; end
        chk("drain_timeout", n < 60, 1);
        inject = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the team's single-port block RAM configured with registered address and registered output (ADDR_PIPELINE and DOUT_PIPELINE = "TRUE"). It accepts one read or write transaction at a time from either requester and drives the RAM's control pins through the required multi-cycle sequence. It captures read data and returns a single-cycle response to the owning requester. It sits between the client logic and the RAM; nothing else drives the RAM pins.

## Interface
- MEM_WIDTH, 16, data width; must match the RAM
- ADDR_SIZE, 10, address width; must match the RAM
- Clocking and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid_0 / req_valid_1  in  1  request present
- req_write_0 / req_write_1  in  1  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  ADDR_SIZE  address
- req_wdata_0 / req_wdata_1  in  MEM_WIDTH  write data
- req_ready_0 / req_ready_1  out  1  request accepted this cycle (combinational)
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle completion pulse to owner
- rsp_rdata  out  MEM_WIDTH  read data, shared, valid with rsp_valid_*
- rsp_err  out  1  parity error flag, valid with rsp_valid_*
- busy  out  1  FSM not in IDLE
- ram_addr  out  ADDR_SIZE  latched transaction address
- ram_din  out  MEM_WIDTH  latched write data
- ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en  out  1  RAM controls
- ram_dout  in  MEM_WIDTH  RAM output
- ram_parity_out  in  1  RAM parity output

## Operation
- FSM states:
  - IDLE → ADDR on accept.
  - ADDR → WRITE if the transaction is a write, else → READ.
  - WRITE → IDLE.
  - READ → DOUT → CAPT → IDLE.
- Accept happens only in IDLE and is a single cycle.
  - Exactly one req_ready_x is high, for the winner, and only when its req_valid_x is high.
  - The write flag, address and data are latched at the end of the accept cycle.
- Round robin uses a `last` register (reset 1, so requester 0 wins first).
  - When both requesters are valid, the one not equal to `last` wins.
  - When only one is valid, it wins.
  - `last` updates on every accept.
- RAM drive per state (unlisted controls are 0):
  - IDLE: all controls 0.
  - ADDR: ram_addr_en=1.
  - WRITE: ram_addr_en=1, ram_blk_select=1, ram_wr_en=1.
  - READ: ram_blk_select=1, ram_rd_en=1, ram_addr_en=0.
  - DOUT: ram_dout_en=1.
  - CAPT: ram_dout is valid; it is registered into rsp_rdata.
- ram_addr and ram_din hold the latched values from ADDR through the end of the transaction.
- Responses are registered.
  - rsp_valid_<owner> pulses for 1 cycle, in the cycle after WRITE or after CAPT.
  - rsp_rdata holds the last read value until the next CAPT; write responses leave it unchanged.
  - A new request may be accepted in the same cycle the response pulses.
- Reset values:
  - FSM=IDLE, last=1.
  - All ram_* outputs 0, rsp_valid_* 0, rsp_rdata 0, rsp_err 0, busy 0.
  - req_ready_* follow the IDLE rule.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and the next cycle is IDLE. A write is committed only if the WRITE cycle completed.

## Timing
- The accept cycle is cycle 0.
- Write: ADDR=1, WRITE=2; RAM updated at the end of cycle 2; rsp_valid in cycle 3.
  - Throughput: one write per 3 cycles.
- Read: ADDR=1, READ=2, DOUT=3, CAPT=4; rsp_valid and rsp_rdata in cycle 5.
  - Throughput: one read per 5 cycles.
- req_ready_* is 0 whenever busy=1.
- Requests are never dropped: a valid requester holds its request until it sees ready.

## Configuration
- RAM_PARITY_CHECK_EN defined:
  - In CAPT, rsp_err is registered as (^ram_dout) != ram_parity_out and presented with that read's response.
  - rsp_err is 0 for writes.
- RAM_PARITY_CHECK_EN undefined:
  - rsp_err is constant 0 and ram_parity_out is ignored.
  - The port list is unchanged.

## Test plan
- Write then read, both from requester 0:
  - Write 0x1234 to 0x005 → rsp_valid_0 in cycle 3.
  - Read 0x005 → rsp_valid_0 in cycle 5 with rsp_rdata=0x1234 and rsp_err=0.
- Both requesters valid in the same cycle after reset:
  - Writes are to 0x010 and 0x011 respectively.
  - Requester 0 is granted first; requester 1 is accepted in the cycle of the first rsp_valid_0.
  - A following dual read is granted to requester 0 first again, since `last`=1.
- Back-to-back reads from requester 1 only → accepts spaced exactly 5 cycles apart, no bubbles beyond the FSM length.
- Assert rst during DOUT of a read:
  - No rsp_valid is issued and all ram_* outputs are 0 the next cycle.
  - A new request is accepted immediately after reset deasserts.
- With RAM_PARITY_CHECK_EN, force ram_parity_out inverted during CAPT → rsp_err=1 with rsp_valid. Without the macro → rsp_err=0.
- Check the RAM pin sequence cycle by cycle for one write and one read: the ram_addr_en, ram_blk_select, ram_wr_en, ram_rd_en and ram_dout_en patterns match the Operation section exactly.
